// File: rtl/fpu_req_arbiter_if.sv
// Requester, response and FPU-side signals of the shared FPU arbiter.
// slave = arbiter side, master = requesters / consumer / FPU side.
interface fpu_req_arbiter_if #(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = $clog2(N)
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [2*N-1:0]  req_op;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_timeout;

    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic [1:0]      fpu_opcode;
    logic            fpu_start;
    logic            fpu_rst;
    logic            fpu_done;
    logic [31:0]     fpu_s;

    logic            busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, fpu_done, fpu_s,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
               fpu_a, fpu_b, fpu_opcode, fpu_start, fpu_rst, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, fpu_done, fpu_s,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout,
               fpu_a, fpu_b, fpu_opcode, fpu_start, fpu_rst, busy
    );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one start/done FPU among N requesters,
// with a completion watchdog that resets the FPU and returns a tagged timeout.
module fpu_req_arbiter #(
    parameter int unsigned N          = 2,
    parameter int unsigned IDW        = $clog2(N),
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    fpu_req_arbiter_if.slave   bus
);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RECOVER, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic            armed_q, armed_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [RCW-1:0]  rc_q, rc_d;
    logic [31:0]     fpu_a_q, fpu_a_d;
    logic [31:0]     fpu_b_q, fpu_b_d;
    logic [1:0]      fpu_op_q, fpu_op_d;
    logic            start_q, start_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_to_q, rsp_to_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;

    logic [31:0]     a_arr  [N];
    logic [31:0]     b_arr  [N];
    logic [1:0]      op_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign a_arr[g]  = bus.req_a[32*g +: 32];
        assign b_arr[g]  = bus.req_b[32*g +: 32];
        assign op_arr[g] = bus.req_op[2*g +: 2];
    end

    // First valid requester at or after rr_ptr, wrapping modulo N
    always_comb begin : grant_search
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % N);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin : fsm_next
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        armed_d     = armed_q;
        wd_d        = wd_q;
        rc_d        = rc_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        start_d     = start_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_to_d    = rsp_to_q;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    fpu_a_d  = a_arr[grant_idx];
                    fpu_b_d  = b_arr[grant_idx];
                    fpu_op_d = op_arr[grant_idx];
                    cur_id_d = grant_idx;
                    rr_ptr_d = IDW'((int'(grant_idx) + 1) % N);
                    start_d  = 1'b1;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                armed_d = 1'b0;
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done seen before the FPU ever drops done is stale
                if (armed_q && bus.fpu_done) begin
                    rsp_data_d  = bus.fpu_s;
                    rsp_to_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    start_d     = 1'b0;
                    state_d     = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_to_d   = 1'b1;
                    start_d    = 1'b0;
                    rc_d       = '0;
                    state_d    = S_RECOVER;
                end else begin
                    wd_d = wd_q + WDW'(1);
                    if (!bus.fpu_done) armed_d = 1'b1;
                end
            end
            S_RECOVER: begin
                if (rc_q == RCW'(RST_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    state_d     = S_RESP;
                end else begin
                    rc_d = rc_q + RCW'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            armed_q     <= 1'b0;
            wd_q        <= '0;
            rc_q        <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            armed_q     <= armed_d;
            wd_q        <= wd_d;
            rc_q        <= rc_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    // Grant is offered only while idle so it doubles as the accept strobe
    assign bus.req_ready   = (state_q == S_IDLE && !rst && grant_found)
                             ? (N'(1) << grant_idx) : '0;
    assign bus.fpu_rst     = rst | (state_q == S_RECOVER);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.fpu_a       = fpu_a_q;
    assign bus.fpu_b       = fpu_b_q;
    assign bus.fpu_opcode  = fpu_op_q;
    assign bus.fpu_start   = start_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_timeout = rsp_to_q;
endmodule
